digital_timer: RTL and testbench
================================

DIGITAL_TIMER -- requirements
Module: digital_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1: one count tick every PRESCALE clk cycles; legal range 1..65536.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-004 The block SHALL have port set_timer  input  1  one-cycle load strobe from the memory management unit.
REQ-005 The block SHALL have port timer_set_val  input  32  load/reload count, sampled only when set_timer=1.
REQ-006 The block SHALL have port timer_periodic  input  1  mode select (0 one-shot, 1 periodic), sampled only when set_timer=1.
REQ-007 The block SHALL have port timer_clear  input  1  acknowledge strobe; clears timer_is_high.
REQ-008 The block SHALL have port timer_stop  input  1  halts counting.
REQ-009 The block SHALL have port timer_is_high  output  1  registered expiry flag, sticky until cleared.
REQ-010 The block SHALL have port timer_count  output  32  registered current count.
REQ-011 The block SHALL have port timer_running  output  1  high while state is RUNNING.
REQ-012 The block SHALL have port timer_missed  output  8  saturating count of expiries occurring while timer_is_high was already 1.

Function
REQ-013 States SHALL be IDLE, RUNNING, EXPIRED; all outputs SHALL be registered.
REQ-014 set_timer=1 in any state SHALL do the following at that edge: latch reload=timer_set_val and mode=timer_periodic; set count=timer_set_val; clear prescaler; clear timer_is_high; clear timer_missed.
REQ-015 After the load, the next state SHALL be RUNNING if timer_set_val!=0.
REQ-016 If timer_set_val=0, the next state SHALL be EXPIRED with timer_is_high=1 at the same edge.
REQ-017 Prescaler: counts 0..PRESCALE-1 in RUNNING only, wraps to 0; a tick occurs on cycles where prescaler=PRESCALE-1 (every cycle when PRESCALE=1).
REQ-018 On a tick in RUNNING with count>1, count SHALL decrement by 1.
REQ-019 On a tick in RUNNING with count=1 (expiry), timer_is_high SHALL become 1 at that edge; latency is exactly N*PRESCALE cycles from the set_timer edge for load value N.
REQ-020 One-shot expiry SHALL set count=0 and go to EXPIRED.
REQ-021 Periodic expiry SHALL set count=reload and remain in RUNNING, with no lost cycle between periods.
REQ-022 An expiry while timer_is_high=1 already SHALL increment timer_missed, saturating at 255 with no wrap.
REQ-023 timer_clear=1 SHALL clear timer_is_high at that edge, without affecting state or count.
REQ-024 If timer_clear and an expiry coincide, the expiry SHALL win: timer_is_high stays 1 and timer_missed is unchanged.
REQ-025 If set_timer coincides with timer_clear, timer_stop or an expiry, set_timer SHALL win per REQ-014..016.
REQ-026 timer_stop=1 (without set_timer) SHALL move to IDLE, hold count, clear prescaler, and leave timer_is_high unchanged.
REQ-027 EXPIRED SHALL hold count=0 until set_timer; timer_clear in EXPIRED SHALL leave the state EXPIRED.
REQ-028 IDLE SHALL ignore timer_clear except for clearing timer_is_high; only set_timer leaves IDLE.
REQ-029 Arithmetic SHALL be 32-bit unsigned; count never underflows below 0.

Reset
REQ-030 While rst=0, state SHALL be IDLE and timer_is_high=0, timer_count=0, timer_running=0, timer_missed=0; reload, mode and prescaler SHALL be 0.
REQ-031 An asynchronous reset mid-count SHALL abort the count with no expiry flagged.
REQ-032 The first edge after rst deasserts SHALL behave as a normal IDLE cycle.

Verification
REQ-033 PRESCALE=1, set_timer with value 5, one-shot -> timer_running=1 for 5 cycles; timer_is_high=1 exactly 5 cycles after the set edge; count=0; state EXPIRED.
REQ-034 PRESCALE=4, value 3, periodic -> timer_is_high rises at cycle 12; count reloads to 3; no timer_clear for two further periods -> timer_missed=2 at cycles 24 and 36.
REQ-035 Load value 0 -> timer_is_high=1 on the next cycle; timer_running=0.
REQ-036 Periodic value 2: timer_clear pulsed on the expiry cycle -> timer_is_high remains 1; set_timer with value 7 on an expiry cycle -> timer_is_high=0, count=7.
REQ-037 timer_stop at count=4 -> count held at 4 for 10 cycles; set_timer then restarts the timer.
REQ-038 rst=0 asserted asynchronously mid-count at count=9 -> all outputs 0 immediately; no expiry after release.
REQ-039 A bench forcing 300 periodic expiries without timer_clear -> timer_missed saturates at 255.

Source files
------------

// File: rtl/digital_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic modes,
// a sticky expiry flag and a saturating count of missed expiries.
module digital_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_timer,
    input  logic [31:0] timer_set_val,
    input  logic        timer_periodic,
    input  logic        timer_clear,
    input  logic        timer_stop,
    output logic        timer_is_high,
    output logic [31:0] timer_count,
    output logic        timer_running,
    output logic [7:0]  timer_missed
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    logic [1:0]      state;
    logic [31:0]     reload;
    logic            mode;
    logic [PS_W-1:0] prescaler;
    logic            tick;

    assign tick = (state == RUNNING) && (prescaler == PS_LAST);

    // NOTE: every register here updates with <= so all of them see the
    // pre-edge values of each other, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            reload        <= '0;
            mode          <= 1'b0;
            prescaler     <= '0;
            timer_is_high <= 1'b0;
            timer_count   <= '0;
            timer_running <= 1'b0;
            timer_missed  <= '0;
        end else if (set_timer) begin
            reload        <= timer_set_val;
            mode          <= timer_periodic;
            timer_count   <= timer_set_val;
            prescaler     <= '0;
            timer_missed  <= '0;
            if (timer_set_val == 32'd0) begin
                state         <= EXPIRED;
                timer_running <= 1'b0;
                timer_is_high <= 1'b1;
            end else begin
                state         <= RUNNING;
                timer_running <= 1'b1;
                timer_is_high <= 1'b0;
            end
        end else if (timer_stop) begin
            state         <= IDLE;
            timer_running <= 1'b0;
            prescaler     <= '0;
            if (timer_clear)
                timer_is_high <= 1'b0;
        end else begin
            if (timer_clear)
                timer_is_high <= 1'b0;
            if (state == RUNNING) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    if (timer_count > 32'd1) begin
                        timer_count <= timer_count - 32'd1;
                    end else if (timer_count == 32'd1) begin
                        // Later assignment overrides a coincident clear: expiry wins.
                        timer_is_high <= 1'b1;
                        if (timer_is_high && (timer_missed != 8'hFF))
                            timer_missed <= timer_missed + 8'd1;
                        if (mode) begin
                            timer_count <= reload;
                        end else begin
                            timer_count   <= '0;
                            state         <= EXPIRED;
                            timer_running <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_digital_timer.sv
// Directed bench for digital_timer: expectations are queued as stimulus is
// applied and drained against a PRESCALE=1 and a PRESCALE=4 instance.
module tb_digital_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_timer;
    logic [31:0] timer_set_val;
    logic        timer_periodic;
    logic        timer_clear;
    logic        timer_stop;

    logic        high1, run1, high4, run4;
    logic [31:0] count1, count4;
    logic [7:0]  missed1, missed4;

    int vectors = 0;
    int miscompares = 0;

    typedef enum int {S_HIGH, S_COUNT, S_RUN, S_MISSED,
                      S_HIGH4, S_COUNT4, S_RUN4, S_MISSED4} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    digital_timer #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .set_timer(set_timer), .timer_set_val(timer_set_val),
        .timer_periodic(timer_periodic), .timer_clear(timer_clear), .timer_stop(timer_stop),
        .timer_is_high(high1), .timer_count(count1), .timer_running(run1),
        .timer_missed(missed1)
    );

    digital_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .set_timer(set_timer), .timer_set_val(timer_set_val),
        .timer_periodic(timer_periodic), .timer_clear(timer_clear), .timer_stop(timer_stop),
        .timer_is_high(high4), .timer_count(count4), .timer_running(run4),
        .timer_missed(missed4)
    );

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            S_HIGH:    return {31'd0, high1};
            S_COUNT:   return count1;
            S_RUN:     return {31'd0, run1};
            S_MISSED:  return {24'd0, missed1};
            S_HIGH4:   return {31'd0, high4};
            S_COUNT4:  return count4;
            S_RUN4:    return {31'd0, run4};
            default:   return {24'd0, missed4};
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [31:0] v, input logic periodic);
        set_timer      = 1'b1;
        timer_set_val  = v;
        timer_periodic = periodic;
        cyc(1);
        set_timer      = 1'b0;
    endtask

    initial begin
        rst = 1'b0; set_timer = 1'b0; timer_set_val = '0;
        timer_periodic = 1'b0; timer_clear = 1'b0; timer_stop = 1'b0;

        // Reset state, before any clock edge
        #3;
        push("rst_high", S_HIGH, 0);   push("rst_count", S_COUNT, 0);
        push("rst_run", S_RUN, 0);     push("rst_missed", S_MISSED, 0);
        drain();
        @(negedge clk); rst = 1'b1;
        cyc(1);
        push("idle_count", S_COUNT, 0); push("idle_run", S_RUN, 0);
        drain();

        // One-shot value 5
        load(32'd5, 1'b0);
        push("os_load_count", S_COUNT, 5); push("os_load_run", S_RUN, 1);
        push("os_load_high", S_HIGH, 0);
        drain();
        for (int k = 1; k < 5; k++) begin
            cyc(1);
            push("os_count", S_COUNT, 32'(5 - k)); push("os_run", S_RUN, 1);
            push("os_high", S_HIGH, 0);
            drain();
        end
        cyc(1);
        push("os_exp_high", S_HIGH, 1); push("os_exp_count", S_COUNT, 0);
        push("os_exp_run", S_RUN, 0);
        drain();
        timer_clear = 1'b1; cyc(1); timer_clear = 1'b0;
        push("exp_clear_high", S_HIGH, 0); push("exp_clear_run", S_RUN, 0);
        drain();
        cyc(3);
        push("exp_hold_count", S_COUNT, 0); push("exp_hold_run", S_RUN, 0);
        drain();

        // Load value 0
        load(32'd0, 1'b0);
        push("zero_high", S_HIGH, 1); push("zero_run", S_RUN, 0);
        push("zero_count", S_COUNT, 0);
        drain();

        // Periodic value 2: clear coinciding with expiry, then reload on expiry
        load(32'd2, 1'b1);
        push("p2_high", S_HIGH, 0); push("p2_count", S_COUNT, 2);
        drain();
        cyc(1);
        push("p2_count1", S_COUNT, 1);
        drain();
        timer_clear = 1'b1; cyc(1); timer_clear = 1'b0;
        push("p2_clr_exp_high", S_HIGH, 1); push("p2_clr_exp_count", S_COUNT, 2);
        push("p2_clr_exp_missed", S_MISSED, 0); push("p2_clr_exp_run", S_RUN, 1);
        drain();
        timer_clear = 1'b1; cyc(1); timer_clear = 1'b0;
        push("p2_clear_high", S_HIGH, 0); push("p2_clear_count", S_COUNT, 1);
        drain();
        load(32'd7, 1'b1);
        push("p2_set_on_exp_high", S_HIGH, 0); push("p2_set_on_exp_count", S_COUNT, 7);
        push("p2_set_on_exp_missed", S_MISSED, 0);
        drain();

        // Stop at count 4, hold, restart
        cyc(3);
        push("pre_stop_count", S_COUNT, 4);
        drain();
        timer_stop = 1'b1; cyc(1); timer_stop = 1'b0;
        push("stop_run", S_RUN, 0); push("stop_count", S_COUNT, 4);
        drain();
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            push("stop_hold_count", S_COUNT, 4);
            drain();
        end
        load(32'd3, 1'b0);
        push("restart_count", S_COUNT, 3); push("restart_run", S_RUN, 1);
        drain();
        cyc(1);
        push("restart_dec", S_COUNT, 2);
        drain();

        // Asynchronous reset mid-count at 9
        load(32'd20, 1'b0);
        cyc(11);
        push("pre_rst_count", S_COUNT, 9);
        drain();
        #2 rst = 1'b0;
        #1;
        push("arst_count", S_COUNT, 0); push("arst_run", S_RUN, 0);
        push("arst_high", S_HIGH, 0);   push("arst_missed", S_MISSED, 0);
        drain();
        @(negedge clk); rst = 1'b1;
        cyc(1);
        for (int k = 0; k < 25; k++) begin
            cyc(1);
            push("post_rst_high", S_HIGH, 0); push("post_rst_run", S_RUN, 0);
            drain();
        end

        // PRESCALE=4, periodic value 3
        load(32'd3, 1'b1);
        push("ps4_load_count", S_COUNT4, 3); push("ps4_load_run", S_RUN4, 1);
        drain();
        cyc(11);
        push("ps4_c11_high", S_HIGH4, 0); push("ps4_c11_count", S_COUNT4, 1);
        drain();
        cyc(1);
        push("ps4_c12_high", S_HIGH4, 1); push("ps4_c12_count", S_COUNT4, 3);
        push("ps4_c12_missed", S_MISSED4, 0); push("ps4_c12_run", S_RUN4, 1);
        drain();
        cyc(11);
        push("ps4_c23_missed", S_MISSED4, 0);
        drain();
        cyc(1);
        push("ps4_c24_missed", S_MISSED4, 1);
        drain();
        cyc(12);
        push("ps4_c36_missed", S_MISSED4, 2); push("ps4_c36_count", S_COUNT4, 3);
        drain();

        // Missed-count saturation with an expiry every cycle
        load(32'd1, 1'b1);
        push("sat_load_high", S_HIGH, 0); push("sat_load_count", S_COUNT, 1);
        drain();
        cyc(255);
        push("sat_254", S_MISSED, 254); push("sat_high", S_HIGH, 1);
        drain();
        cyc(1);
        push("sat_255", S_MISSED, 255);
        drain();
        cyc(44);
        push("sat_hold", S_MISSED, 255); push("sat_count", S_COUNT, 1);
        drain();
        load(32'd4, 1'b0);
        push("sat_reload_missed", S_MISSED, 0); push("sat_reload_high", S_HIGH, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
